// File: rtl/loader_pkg.sv
// Shared types and constants for the debug RAM loader: FSM states, BRAM select
// encodings, the full-word write strobe and a word-to-byte address helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    HOLD     = 3'd2,
    RUN      = 3'd3,
    DUMP_RD  = 3'd4,
    DUMP_OUT = 3'd5
  } loader_state_e;

  localparam logic RAM_SEL_DATA = 1'b0;
  localparam logic RAM_SEL_INST = 1'b1;

  localparam logic [3:0] WE_ALL = 4'b1111;

  function automatic logic [31:0] byte_addr(input logic [31:0] word_index);
    return word_index << 2;
  endfunction

endpackage

// File: rtl/reset_hold_timer.sv
// Loadable down-counter that stretches the core reset after an image load;
// done is high whenever the count has reached zero.
module reset_hold_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/debug_ram_loader.sv
// Streams an image into the data or instruction BRAM, holds the core in reset
// while loading/dumping, and reads a BRAM back out. Optional: LOADER_CHECKSUM_EN.
module debug_ram_loader
  import loader_pkg::*;
#(
  parameter int BRAM_WORDS = 4096,
  parameter int RST_HOLD   = 5
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [31:0] S_DATA,
  input  logic        S_LAST,
  input  logic        RAM_SEL,
  input  logic        START_DUMP,
  output logic        DUMP_VALID,
  input  logic        DUMP_READY,
  output logic [31:0] DUMP_ADDR,
  output logic [31:0] DUMP_DATA,
  output logic        CORE_RST,
  output logic        LOAD_OVF,
  output logic [31:0] LOAD_CSUM,
  output logic [31:0] DataRAM_A2,
  output logic [31:0] DataRAM_WD2,
  output logic [3:0]  DataRAM_WE2,
  input  logic [31:0] DataRAM_RD2,
  output logic [31:0] InstRAM_A2,
  output logic [31:0] InstRAM_WD2,
  output logic [3:0]  InstRAM_WE2,
  input  logic [31:0] InstRAM_RD2
);

  localparam int IW = $clog2(BRAM_WORDS) + 1;
  localparam int HW = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [IW-1:0] WORDS_LIM = IW'(BRAM_WORDS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(BRAM_WORDS - 1);

  loader_state_e state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic          sel_q, sel_d;
  logic          ovf_q, ovf_d;
  logic          dump_valid_q, dump_valid_d;
  logic [31:0]   dump_addr_q, dump_addr_d;
  logic [31:0]   dump_data_q, dump_data_d;
  logic          cap_q, cap_d;

  logic          wr_en;
  logic          rd_active;
  logic          port_sel;
  logic [31:0]   port_addr;
  logic          hold_load;
  logic          hold_done;
  logic [31:0]   rd_data;

  reset_hold_timer #(
    .WIDTH(HW)
  ) u_hold (
    .clk       (CPU_CLK),
    .rst       (CPU_RST),
    .load      (hold_load),
    .load_value(HW'(RST_HOLD)),
    .count_en  (state_q == HOLD),
    .done      (hold_done)
  );

  assign S_READY  = !CPU_RST && ((state_q == IDLE) || (state_q == LOAD) || (state_q == RUN));
  assign CORE_RST = CPU_RST || (state_q != RUN);
  assign rd_data  = (sel_q == RAM_SEL_INST) ? InstRAM_RD2 : DataRAM_RD2;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    sel_d        = sel_q;
    ovf_d        = ovf_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    cap_d        = 1'b0;
    wr_en        = 1'b0;
    rd_active    = 1'b0;
    port_sel     = sel_q;
    port_addr    = byte_addr(32'(index_q));
    hold_load    = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        // A new image always starts at word 0 of the BRAM chosen on its first word.
        if (S_VALID) begin
          wr_en     = 1'b1;
          port_sel  = RAM_SEL;
          port_addr = '0;
          sel_d     = RAM_SEL;
          index_d   = IW'(1);
          if (S_LAST) begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (START_DUMP) begin
          sel_d   = RAM_SEL;
          index_d = '0;
          state_d = DUMP_RD;
        end
      end

      LOAD: begin
        // Past the end of the BRAM words are swallowed and the index saturates.
        if (S_VALID) begin
          if (index_q < WORDS_LIM) begin
            wr_en   = 1'b1;
            index_d = index_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (S_LAST) begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end
        end
      end

      HOLD: begin
        if (hold_done) begin
          state_d = RUN;
        end
      end

      DUMP_RD: begin
        rd_active    = 1'b1;
        state_d      = DUMP_OUT;
        dump_valid_d = 1'b1;
        dump_addr_d  = port_addr;
        cap_d        = 1'b1;
      end

      DUMP_OUT: begin
        // RD2 is only valid one cycle after DUMP_RD; latch it then and hold it.
        rd_active = 1'b1;
        if (cap_q) begin
          dump_data_d = rd_data;
        end
        if (DUMP_READY) begin
          dump_valid_d = 1'b0;
          if (index_q < LAST_IDX) begin
            index_d = index_q + 1'b1;
            state_d = DUMP_RD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    DataRAM_A2  = '0;
    DataRAM_WD2 = '0;
    DataRAM_WE2 = '0;
    InstRAM_A2  = '0;
    InstRAM_WD2 = '0;
    InstRAM_WE2 = '0;
    if (!CPU_RST && (wr_en || rd_active)) begin
      if (port_sel == RAM_SEL_INST) begin
        InstRAM_A2  = port_addr;
        InstRAM_WD2 = wr_en ? S_DATA : '0;
        InstRAM_WE2 = wr_en ? WE_ALL : '0;
      end else if (port_sel == RAM_SEL_DATA) begin
        DataRAM_A2  = port_addr;
        DataRAM_WD2 = wr_en ? S_DATA : '0;
        DataRAM_WE2 = wr_en ? WE_ALL : '0;
      end
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q      <= IDLE;
      index_q      <= '0;
      sel_q        <= RAM_SEL_DATA;
      ovf_q        <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      cap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      sel_q        <= sel_d;
      ovf_q        <= ovf_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      cap_q        <= cap_d;
    end
  end

  assign LOAD_OVF   = ovf_q;
  assign DUMP_VALID = dump_valid_q;
  assign DUMP_ADDR  = dump_addr_q;
  assign DUMP_DATA  = ((state_q == DUMP_OUT) && cap_q) ? rd_data : dump_data_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  logic        new_image;

  assign new_image = (state_q == IDLE) || (state_q == RUN);

  always_comb begin
    csum_d = csum_q;
    if (S_VALID && S_READY) begin
      csum_d = new_image ? S_DATA : (csum_q + S_DATA);
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign LOAD_CSUM = csum_q;
`else
  assign LOAD_CSUM = '0;
`endif

endmodule

// File: tb/tb_debug_ram_loader.sv
// Scoreboard bench for debug_ram_loader (8-word BRAMs): expected writes and dump
// beats are queued at issue time and popped by negedge monitors.
module tb_debug_ram_loader;

  localparam int WORDS    = 8;
  localparam int RST_HOLD = 5;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic        S_VALID;
  logic        S_READY;
  logic [31:0] S_DATA;
  logic        S_LAST;
  logic        RAM_SEL;
  logic        START_DUMP;
  logic        DUMP_VALID;
  logic        DUMP_READY;
  logic [31:0] DUMP_ADDR;
  logic [31:0] DUMP_DATA;
  logic        CORE_RST;
  logic        LOAD_OVF;
  logic [31:0] LOAD_CSUM;
  logic [31:0] DataRAM_A2, DataRAM_WD2, DataRAM_RD2;
  logic [3:0]  DataRAM_WE2;
  logic [31:0] InstRAM_A2, InstRAM_WD2, InstRAM_RD2;
  logic [3:0]  InstRAM_WE2;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } dump_exp_t;

  wr_exp_t     exp_wr[$];
  dump_exp_t   exp_dump[$];
  logic [31:0] img_words[$];

  logic [31:0] bram_data[WORDS];
  logic [31:0] bram_inst[WORDS];
  logic [31:0] ref_mem[2][WORDS];

  int          n_checks   = 0;
  int          n_failures = 0;
  int          model_idx  = 0;
  logic        model_sel  = 1'b0;
  logic        model_ovf  = 1'b0;
  logic [31:0] model_csum = '0;

  int          stall_fixed = -1;
  int          stall_cnt   = 0;
  bit          have_last   = 0;
  logic [31:0] last_addr, last_data;

  debug_ram_loader #(
    .BRAM_WORDS(WORDS),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RST    (CPU_RST),
    .S_VALID    (S_VALID),
    .S_READY    (S_READY),
    .S_DATA     (S_DATA),
    .S_LAST     (S_LAST),
    .RAM_SEL    (RAM_SEL),
    .START_DUMP (START_DUMP),
    .DUMP_VALID (DUMP_VALID),
    .DUMP_READY (DUMP_READY),
    .DUMP_ADDR  (DUMP_ADDR),
    .DUMP_DATA  (DUMP_DATA),
    .CORE_RST   (CORE_RST),
    .LOAD_OVF   (LOAD_OVF),
    .LOAD_CSUM  (LOAD_CSUM),
    .DataRAM_A2 (DataRAM_A2),
    .DataRAM_WD2(DataRAM_WD2),
    .DataRAM_WE2(DataRAM_WE2),
    .DataRAM_RD2(DataRAM_RD2),
    .InstRAM_A2 (InstRAM_A2),
    .InstRAM_WD2(InstRAM_WD2),
    .InstRAM_WE2(InstRAM_WE2),
    .InstRAM_RD2(InstRAM_RD2)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Synchronous-read BRAM models, one cycle of read latency.
  always @(posedge CPU_CLK) begin
    if (DataRAM_WE2 == 4'hF) bram_data[DataRAM_A2[4:2]] <= DataRAM_WD2;
    if (InstRAM_WE2 == 4'hF) bram_inst[InstRAM_A2[4:2]] <= InstRAM_WD2;
    DataRAM_RD2 <= bram_data[DataRAM_A2[4:2]];
    InstRAM_RD2 <= bram_inst[InstRAM_A2[4:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe seen must match the oldest expected write.
  always @(negedge CPU_CLK) begin
    if (DataRAM_WE2 != 4'h0 || InstRAM_WE2 != 4'h0) begin
      wr_exp_t e;
      logic    sel;
      sel = (InstRAM_WE2 != 4'h0);
      if (DataRAM_WE2 != 4'h0 && InstRAM_WE2 != 4'h0)
        checkOutput("wr_both_ports", 32'd1, 32'd0);
      if (exp_wr.size() == 0) begin
        checkOutput("wr_unexpected", sel ? InstRAM_A2 : DataRAM_A2, 32'hFFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        checkOutput("wr_port", {31'd0, sel}, {31'd0, e.sel});
        checkOutput("wr_strobe", {28'd0, sel ? InstRAM_WE2 : DataRAM_WE2}, 32'hF);
        checkOutput("wr_addr", sel ? InstRAM_A2 : DataRAM_A2, e.addr);
        checkOutput("wr_data", sel ? InstRAM_WD2 : DataRAM_WD2, e.data);
      end
    end
  end

  // Dump monitor: stability while stalled, compare on handshake.
  always @(negedge CPU_CLK) begin
    if (!CPU_RST && DUMP_VALID) begin
      checkOutput("core_rst_in_dump", {31'd0, CORE_RST}, 32'd1);
      if (have_last) begin
        checkOutput("dump_addr_stable", DUMP_ADDR, last_addr);
        checkOutput("dump_data_stable", DUMP_DATA, last_data);
      end
      if (DUMP_READY) begin
        if (exp_dump.size() == 0) begin
          checkOutput("dump_unexpected", DUMP_ADDR, 32'hFFFF_FFFF);
        end else begin
          dump_exp_t d;
          d = exp_dump.pop_front();
          checkOutput("dump_addr", DUMP_ADDR, d.addr);
          checkOutput("dump_data", DUMP_DATA, d.data);
        end
        have_last = 0;
        stall_cnt = 0;
      end else begin
        have_last = 1;
        last_addr = DUMP_ADDR;
        last_data = DUMP_DATA;
        stall_cnt++;
      end
    end
  end

  initial begin
    DUMP_READY = 1'b0;
    forever begin
      @(posedge CPU_CLK);
      #1;
      if (stall_fixed >= 0) DUMP_READY = (stall_cnt >= stall_fixed);
      else DUMP_READY = ($urandom_range(0, 1) == 1);
    end
  end

  // Drive one word; the model decides where it must land before the edge.
  task automatic applyStimulus(input logic [31:0] data, input logic last,
                               input logic sel, input bit first);
    wr_exp_t e;
    if (first) begin
      model_idx  = 0;
      model_sel  = sel;
      model_csum = '0;
    end
    if (model_idx < WORDS) begin
      e.sel  = model_sel;
      e.addr = 32'(model_idx) * 4;
      e.data = data;
      exp_wr.push_back(e);
      ref_mem[model_sel][model_idx] = data;
    end else begin
      model_ovf = 1'b1;
    end
    model_idx++;
    model_csum = model_csum + data;
    S_VALID = 1'b1;
    S_DATA  = data;
    S_LAST  = last;
    RAM_SEL = sel;
    @(negedge CPU_CLK);
    checkOutput("s_ready", {31'd0, S_READY}, 32'd1);
    @(posedge CPU_CLK);
    #1;
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    S_DATA  = $urandom;
    RAM_SEL = $urandom_range(0, 1);
  endtask

  task automatic loadImage(input logic sel, input bit poke_dump, input bit gaps);
    int n;
    int cnt;
    bit done;
    n = img_words.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge CPU_CLK);
          #1;
        end
      end
      applyStimulus(img_words[i], i == n - 1, sel, i == 0);
    end
    START_DUMP = poke_dump;
    cnt  = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CPU_CLK);
      if (CORE_RST) cnt++;
      else done = 1;
      @(posedge CPU_CLK);
      #1;
      START_DUMP = 1'b0;
    end
    checkOutput("core_rst_hold_cycles", 32'(cnt), 32'(RST_HOLD + 1));
    checkOutput("load_ovf", {31'd0, LOAD_OVF}, {31'd0, model_ovf});
`ifdef LOADER_CHECKSUM_EN
    checkOutput("load_csum", LOAD_CSUM, model_csum);
`else
    checkOutput("load_csum", LOAD_CSUM, 32'd0);
`endif
    if (poke_dump) checkOutput("dump_ignored_in_hold", {31'd0, DUMP_VALID}, 32'd0);
  endtask

  task automatic dumpRam(input logic sel, input int stall);
    dump_exp_t d;
    stall_fixed = stall;
    stall_cnt   = 0;
    for (int i = 0; i < WORDS; i++) begin
      d.addr = 32'(i) * 4;
      d.data = ref_mem[sel][i];
      exp_dump.push_back(d);
    end
    START_DUMP = 1'b1;
    RAM_SEL    = sel;
    @(posedge CPU_CLK);
    #1;
    START_DUMP = 1'b0;
    for (int c = 0; c < 400 && exp_dump.size() != 0; c++) @(negedge CPU_CLK);
    if (exp_dump.size() != 0) begin
      checkOutput("dump_timeout", 32'(exp_dump.size()), 32'd0);
      exp_dump.delete();
    end
    @(posedge CPU_CLK);
    #1;
    @(negedge CPU_CLK);
    checkOutput("dump_end_valid", {31'd0, DUMP_VALID}, 32'd0);
    checkOutput("dump_end_core_rst", {31'd0, CORE_RST}, 32'd1);
    @(posedge CPU_CLK);
    #1;
    stall_fixed = -1;
  endtask

  task automatic randomImage(input int n);
    img_words.delete();
    for (int i = 0; i < n; i++) img_words.push_back($urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      bram_data[i]  = $urandom;
      bram_inst[i]  = $urandom;
      ref_mem[0][i] = bram_data[i];
      ref_mem[1][i] = bram_inst[i];
    end
    CPU_RST    = 1'b1;
    S_VALID    = 1'b0;
    S_DATA     = '0;
    S_LAST     = 1'b0;
    RAM_SEL    = 1'b0;
    START_DUMP = 1'b0;
    repeat (3) @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    checkOutput("rst_s_ready", {31'd0, S_READY}, 32'd0);
    checkOutput("rst_core_rst", {31'd0, CORE_RST}, 32'd1);
    checkOutput("rst_dump_valid", {31'd0, DUMP_VALID}, 32'd0);
    checkOutput("rst_dump_addr", DUMP_ADDR, 32'd0);
    checkOutput("rst_dump_data", DUMP_DATA, 32'd0);
    checkOutput("rst_load_ovf", {31'd0, LOAD_OVF}, 32'd0);
    checkOutput("rst_load_csum", LOAD_CSUM, 32'd0);
    checkOutput("rst_we", {24'd0, DataRAM_WE2, InstRAM_WE2}, 32'd0);
    @(posedge CPU_CLK);
    #1;
    CPU_RST = 1'b0;

    // Three-word instruction image, with a dump request poked during HOLD.
    img_words = '{32'h11, 32'h22, 32'h33};
    loadImage(1'b1, 1'b1, 1'b0);
    checkOutput("run_core_rst", {31'd0, CORE_RST}, 32'd0);

    // Ten-word data image into an 8-word BRAM, word 2 is the dump marker.
    randomImage(10);
    img_words[2] = 32'hDEAD_BEEF;
    loadImage(1'b0, 1'b0, 1'b1);

    dumpRam(1'b0, 3);
    dumpRam(1'b1, -1);

    for (int k = 0; k < 4; k++) begin
      randomImage($urandom_range(1, WORDS + 2));
      loadImage(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      dumpRam(1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1 ? -1 : $urandom_range(0, 3));
    end

    // Abort a load at its third word with CPU_RST.
    applyStimulus($urandom, 1'b0, 1'b0, 1'b1);
    applyStimulus($urandom, 1'b0, 1'b0, 1'b0);
    S_VALID = 1'b1;
    S_DATA  = $urandom;
    CPU_RST = 1'b1;
    @(negedge CPU_CLK);
    checkOutput("abort_s_ready", {31'd0, S_READY}, 32'd0);
    checkOutput("abort_we", {24'd0, DataRAM_WE2, InstRAM_WE2}, 32'd0);
    @(posedge CPU_CLK);
    #1;
    CPU_RST = 1'b0;
    S_VALID = 1'b0;
    model_ovf = 1'b0;
    @(negedge CPU_CLK);
    checkOutput("post_rst_core_rst", {31'd0, CORE_RST}, 32'd1);
    checkOutput("post_rst_load_ovf", {31'd0, LOAD_OVF}, 32'd0);
    checkOutput("post_rst_load_csum", LOAD_CSUM, 32'd0);
    checkOutput("post_rst_we", {24'd0, DataRAM_WE2, InstRAM_WE2}, 32'd0);
    checkOutput("post_rst_dump_valid", {31'd0, DUMP_VALID}, 32'd0);
    @(posedge CPU_CLK);
    #1;

    randomImage(2);
    loadImage(1'b0, 1'b0, 1'b0);
    dumpRam(1'b0, 1);

    checkOutput("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
